// File: rtl/fallthrough_fifo_stat_if.sv
`default_nettype none
// ============================================================================
//  Module      : fallthrough_fifo_stat_if
//  Description : Handshake/status bundle between a producer/consumer pair and
//                the first-word-fall-through FIFO. The master side writes and
//                consumes words; the slave side is the FIFO itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface fallthrough_fifo_stat_if #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
);
    // Producer / consumer requests
    logic [WIDTH-1:0]        din;
    logic                    wr_en;
    logic                    rd_en;
    logic                    err_clear;

    // Head word and status
    logic [WIDTH-1:0]        dout;
    logic                    empty;
    logic                    full;
    logic                    nearly_full;
    logic                    prog_full;
    logic                    prog_empty;
    logic [MAX_DEPTH_BITS:0] data_count;
    logic                    overflow;
    logic                    underflow;

    // User side: drives requests, observes the FIFO
    modport master (
        output din, wr_en, rd_en, err_clear,
        input  dout, empty, full, nearly_full, prog_full, prog_empty,
               data_count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  din, wr_en, rd_en, err_clear,
        output dout, empty, full, nearly_full, prog_full, prog_empty,
               data_count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fallthrough_fifo_stat.sv
`default_nettype none
// ============================================================================
//  Module      : fallthrough_fifo_stat
//  Description : First-word-fall-through FIFO with occupancy count,
//                programmable full/empty thresholds and sticky overflow /
//                underflow flags. Capacity is 2**MAX_DEPTH_BITS words, made of
//                a (DEPTH-1)-entry circular array plus a registered output
//                stage that always holds the head word.
//  Revision    : 1.0  initial release
// ============================================================================
module fallthrough_fifo_stat #(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1
) (
    input  wire logic               clk,
    input  wire logic               reset,
    fallthrough_fifo_stat_if.slave  fifo
);

    // ------------------------------------------------------------------------
    // Geometry
    // ------------------------------------------------------------------------
    localparam int c_DEPTH     = 2**MAX_DEPTH_BITS;
    localparam int c_ARR_DEPTH = c_DEPTH - 1;
    // A one-word FIFO never touches the array; keep one dummy slot so the
    // declarations stay legal.
    localparam int c_ARR_SLOTS = (c_ARR_DEPTH > 0) ? c_ARR_DEPTH : 1;
    localparam int c_PTR_W     = (c_ARR_SLOTS > 1) ? $clog2(c_ARR_SLOTS) : 1;
    localparam int c_CNT_W     = MAX_DEPTH_BITS + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(c_ARR_SLOTS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_DEPTH = c_CNT_W'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]   r_mem [0:c_ARR_SLOTS-1];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_dout;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    // ------------------------------------------------------------------------
    // Decode (all judged on the state at the start of the cycle)
    // ------------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_arr_has_data;
    logic w_bypass;
    logic w_arr_push;
    logic w_arr_pop;
    int   w_count_int;

    assign w_full         = (r_count == c_CNT_DEPTH);
    assign w_empty        = (r_count == '0);
    assign w_wr_acc       = fifo.wr_en && !w_full;
    assign w_rd_acc       = fifo.rd_en && !w_empty;

    // The output stage holds one word, so the array only holds data once the
    // total count exceeds one.
    assign w_arr_has_data = (r_count > c_CNT_ONE);

    // An incoming word goes straight to the output stage when nothing older
    // is waiting in the array to take that slot: either the FIFO is empty, or
    // the sole word is being consumed this cycle.
    assign w_bypass       = w_wr_acc && (w_empty || (w_rd_acc && !w_arr_has_data));
    assign w_arr_push     = w_wr_acc && !w_bypass;
    assign w_arr_pop      = w_rd_acc && w_arr_has_data;

    assign w_count_int    = int'(r_count);

    // ------------------------------------------------------------------------
    // Storage array write port (no reset: contents are don't-care until
    // referenced by a valid pointer range)
    // ------------------------------------------------------------------------
    // Capture pushed words at the tail of the circular array
    always_ff @(posedge clk) begin
        if (!reset && w_arr_push) begin
            r_mem[r_wr_ptr] <= fifo.din;
        end
    end

    // Advance the circular pointers, wrapping after the last array entry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_arr_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_arr_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Load the head word: bypass data or the oldest array entry; otherwise hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout <= '0;
        end else if (w_bypass) begin
            r_dout <= fifo.din;
        end else if (w_arr_pop) begin
            r_dout <= r_mem[r_rd_ptr];
        end
    end

    // Track occupancy: up on write only, down on read only
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a fresh error outranks a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (fifo.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (fifo.err_clear) begin
                r_overflow <= 1'b0;
            end
            if (fifo.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (fifo.err_clear) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: status is purely a function of the registered count, so there
    // is no combinational path from wr_en/rd_en to any flag.
    // Out-of-range thresholds simply make the compares constant.
    // ------------------------------------------------------------------------
    assign fifo.dout        = r_dout;
    assign fifo.data_count  = r_count;
    assign fifo.empty       = w_empty;
    assign fifo.full        = w_full;
    assign fifo.nearly_full = (w_count_int >= (c_DEPTH - 1));
    assign fifo.prog_full   = (w_count_int >= PROG_FULL_THRESHOLD);
    assign fifo.prog_empty  = (w_count_int <= PROG_EMPTY_THRESHOLD);
    assign fifo.overflow    = r_overflow;
    assign fifo.underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fallthrough_fifo_stat.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fallthrough_fifo_stat
//  Description : Directed and scoreboard-driven bench for the fall-through
//                FIFO, WIDTH=32, DEPTH=8, PROG_FULL=6, PROG_EMPTY=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fallthrough_fifo_stat;

    localparam int c_WIDTH = 32;
    localparam int c_MDB   = 3;
    localparam int c_DEPTH = 8;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fallthrough_fifo_stat_if #(.WIDTH(c_WIDTH), .MAX_DEPTH_BITS(c_MDB)) bus ();

    fallthrough_fifo_stat #(
        .WIDTH               (c_WIDTH),
        .MAX_DEPTH_BITS      (c_MDB),
        .PROG_FULL_THRESHOLD (6),
        .PROG_EMPTY_THRESHOLD(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fifo (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.err_clear = 1'b0;
        bus.din       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        cycle();
        cycle();
        checks += 9;
        if (bus.dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.dout); end
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        if (bus.nearly_full !== 1'b0) begin failures++; $display("FAIL reset_nearly_full got=%b exp=0", bus.nearly_full); end
        if (bus.prog_full !== 1'b0) begin failures++; $display("FAIL reset_prog_full got=%b exp=0", bus.prog_full); end
        if (bus.prog_empty !== 1'b1) begin failures++; $display("FAIL reset_prog_empty got=%b exp=1", bus.prog_empty); end
        if (bus.data_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.data_count); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
        if (bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", bus.underflow); end
        reset = 1'b0;
    endtask

    task automatic test_fall_through();
        bus.din   = 32'h1;
        bus.wr_en = 1'b1;
        cycle();
        bus.wr_en = 1'b0;
        checks += 4;
        if (bus.empty !== 1'b0) begin failures++; $display("FAIL ft_empty got=%b exp=0", bus.empty); end
        if (bus.dout !== 32'h1) begin failures++; $display("FAIL ft_dout got=%h exp=1", bus.dout); end
        if (bus.data_count !== 4'd1) begin failures++; $display("FAIL ft_count got=%0d exp=1", bus.data_count); end
        if (bus.prog_empty !== 1'b1) begin failures++; $display("FAIL ft_prog_empty got=%b exp=1", bus.prog_empty); end
    endtask

    // Writes 1..9 from empty; leaves the FIFO full holding 1..8
    task automatic test_fill_overflow();
        int exp_cnt;
        for (int i = 1; i <= 9; i++) begin
            bus.din   = i;
            bus.wr_en = 1'b1;
            cycle();
            exp_cnt = (i > c_DEPTH) ? c_DEPTH : i;
            checks += 7;
            if (bus.data_count !== 4'(exp_cnt)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.data_count, exp_cnt); end
            if (bus.full !== (exp_cnt == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b", i, bus.full); end
            if (bus.nearly_full !== (exp_cnt >= 7)) begin failures++; $display("FAIL fill_nearly_full[%0d] got=%b", i, bus.nearly_full); end
            if (bus.prog_full !== (exp_cnt >= 6)) begin failures++; $display("FAIL fill_prog_full[%0d] got=%b", i, bus.prog_full); end
            if (bus.prog_empty !== (exp_cnt <= 1)) begin failures++; $display("FAIL fill_prog_empty[%0d] got=%b", i, bus.prog_empty); end
            if (bus.overflow !== (i == 9)) begin failures++; $display("FAIL fill_overflow[%0d] got=%b", i, bus.overflow); end
            if (bus.dout !== 32'h1) begin failures++; $display("FAIL fill_dout[%0d] got=%h exp=1", i, bus.dout); end
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            checks += 1;
            if (bus.dout !== 32'(i)) begin failures++; $display("FAIL drain_dout[%0d] got=%h exp=%h", i, bus.dout, i); end
            bus.rd_en = 1'b1;
            cycle();
            checks += 1;
            if (bus.data_count !== 4'(8 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, bus.data_count, 8 - i); end
        end
        checks += 3;
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", bus.empty); end
        if (bus.dout !== 32'h8) begin failures++; $display("FAIL drain_dout_hold got=%h exp=8", bus.dout); end
        if (bus.underflow !== 1'b0) begin failures++; $display("FAIL drain_underflow_early got=%b exp=0", bus.underflow); end
        // Ninth read on an empty FIFO
        cycle();
        checks += 2;
        if (bus.underflow !== 1'b1) begin failures++; $display("FAIL underflow_set got=%b exp=1", bus.underflow); end
        if (bus.data_count !== 4'd0) begin failures++; $display("FAIL underflow_count got=%0d exp=0", bus.data_count); end
        // Clear together with a fresh underflow: underflow stays, overflow clears
        bus.err_clear = 1'b1;
        cycle();
        checks += 2;
        if (bus.underflow !== 1'b1) begin failures++; $display("FAIL clear_vs_new_err got=%b exp=1", bus.underflow); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow got=%b exp=0", bus.overflow); end
        bus.rd_en = 1'b0;
        cycle();
        bus.err_clear = 1'b0;
        checks += 2;
        if (bus.underflow !== 1'b0) begin failures++; $display("FAIL clear_underflow got=%b exp=0", bus.underflow); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow2 got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        do_reset();
        bus.din = 32'h5; bus.wr_en = 1'b1;
        cycle();
        // Count 1: write and read together
        bus.din = 32'hA; bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        checks += 3;
        if (bus.empty !== 1'b0) begin failures++; $display("FAIL b2b1_empty got=%b exp=0", bus.empty); end
        if (bus.dout !== 32'hA) begin failures++; $display("FAIL b2b1_dout got=%h exp=a", bus.dout); end
        if (bus.data_count !== 4'd1) begin failures++; $display("FAIL b2b1_count got=%0d exp=1", bus.data_count); end
        exp_q.push_back(32'hA);
        for (int i = 0; i < 3; i++) begin
            bus.din = 32'h10 + i;
            exp_q.push_back(32'h10 + i);
            cycle();
        end
        // Count 4: twenty concurrent read/write cycles
        bus.rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bus.din = 32'h100 + k;
            checks += 1;
            if (bus.dout !== exp_q[0]) begin failures++; $display("FAIL b2b4_dout[%0d] got=%h exp=%h", k, bus.dout, exp_q[0]); end
            void'(exp_q.pop_front());
            exp_q.push_back(32'h100 + k);
            cycle();
            checks += 1;
            if (bus.data_count !== 4'd4) begin failures++; $display("FAIL b2b4_count[%0d] got=%0d exp=4", k, bus.data_count); end
        end
        bus.wr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks += 1;
            if (bus.dout !== 32'h110 + k) begin failures++; $display("FAIL b2b4_tail[%0d] got=%h exp=%h", k, bus.dout, 32'h110 + k); end
            cycle();
        end
        bus.rd_en = 1'b0;
        checks += 1;
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL b2b4_empty got=%b exp=1", bus.empty); end
    endtask

    task automatic test_edge_cases();
        do_reset();
        bus.wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.din = 32'h20 + i;
            cycle();
        end
        // Full with both requests: write dropped, read accepted
        bus.din = 32'hEE; bus.rd_en = 1'b1;
        cycle();
        idle_inputs();
        checks += 4;
        if (bus.data_count !== 4'd7) begin failures++; $display("FAIL full_rw_count got=%0d exp=7", bus.data_count); end
        if (bus.dout !== 32'h21) begin failures++; $display("FAIL full_rw_dout got=%h exp=21", bus.dout); end
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL full_rw_overflow got=%b exp=1", bus.overflow); end
        if (bus.full !== 1'b0) begin failures++; $display("FAIL full_rw_full got=%b exp=0", bus.full); end
        for (int i = 0; i < 7; i++) begin
            checks += 1;
            if (bus.dout !== 32'h21 + i) begin failures++; $display("FAIL full_rw_order[%0d] got=%h exp=%h", i, bus.dout, 32'h21 + i); end
            bus.rd_en = 1'b1;
            cycle();
        end
        // Empty with both requests: write accepted, underflow flagged
        do_reset();
        bus.din = 32'h77; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
        cycle();
        idle_inputs();
        checks += 4;
        if (bus.data_count !== 4'd1) begin failures++; $display("FAIL empty_rw_count got=%0d exp=1", bus.data_count); end
        if (bus.dout !== 32'h77) begin failures++; $display("FAIL empty_rw_dout got=%h exp=77", bus.dout); end
        if (bus.underflow !== 1'b1) begin failures++; $display("FAIL empty_rw_underflow got=%b exp=1", bus.underflow); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL empty_rw_overflow got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] m_dout;
        logic        m_ovf;
        logic        m_unf;
        logic        wr, rd, ec, m_full, m_empty;
        logic [31:0] d;
        int          phase;
        int          sz;
        do_reset();
        m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            phase = (c / 200) % 2;
            wr = (phase == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rd = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ec = ($urandom_range(0, 31) == 0);
            d  = $urandom;
            bus.wr_en = wr; bus.rd_en = rd; bus.err_clear = ec; bus.din = d;
            m_full  = (q.size() == c_DEPTH);
            m_empty = (q.size() == 0);
            if (rd && !m_empty) void'(q.pop_front());
            if (wr && !m_full) q.push_back(d);
            if (q.size() > 0) m_dout = q[0];
            if (wr && m_full) m_ovf = 1'b1; else if (ec) m_ovf = 1'b0;
            if (rd && m_empty) m_unf = 1'b1; else if (ec) m_unf = 1'b0;
            sz = q.size();
            cycle();
            checks += 9;
            if (bus.dout !== m_dout) begin failures++; $display("FAIL rnd_dout[%0d] got=%h exp=%h", c, bus.dout, m_dout); end
            if (bus.data_count !== 4'(sz)) begin failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", c, bus.data_count, sz); end
            if (bus.empty !== (sz == 0)) begin failures++; $display("FAIL rnd_empty[%0d] got=%b", c, bus.empty); end
            if (bus.full !== (sz == 8)) begin failures++; $display("FAIL rnd_full[%0d] got=%b", c, bus.full); end
            if (bus.nearly_full !== (sz >= 7)) begin failures++; $display("FAIL rnd_nearly_full[%0d] got=%b", c, bus.nearly_full); end
            if (bus.prog_full !== (sz >= 6)) begin failures++; $display("FAIL rnd_prog_full[%0d] got=%b", c, bus.prog_full); end
            if (bus.prog_empty !== (sz <= 1)) begin failures++; $display("FAIL rnd_prog_empty[%0d] got=%b", c, bus.prog_empty); end
            if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow[%0d] got=%b exp=%b", c, bus.overflow, m_ovf); end
            if (bus.underflow !== m_unf) begin failures++; $display("FAIL rnd_underflow[%0d] got=%b exp=%b", c, bus.underflow, m_unf); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midway();
        do_reset();
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din = 32'h31 + i;
            cycle();
        end
        checks += 2;
        if (bus.data_count !== 4'd5) begin failures++; $display("FAIL mid_pre_count got=%0d exp=5", bus.data_count); end
        if (bus.underflow !== 1'b1) begin failures++; $display("FAIL mid_pre_underflow got=%b exp=1", bus.underflow); end
        // Reset while a write is also requested: reset wins
        bus.din = 32'hDEAD; bus.rd_en = 1'b1; reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle_inputs();
        checks += 4;
        if (bus.data_count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", bus.data_count); end
        if (bus.empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b exp=1", bus.empty); end
        if (bus.dout !== 32'h0) begin failures++; $display("FAIL mid_dout got=%h exp=0", bus.dout); end
        if (bus.underflow !== 1'b0) begin failures++; $display("FAIL mid_underflow got=%b exp=0", bus.underflow); end
        bus.din = 32'hB; bus.wr_en = 1'b1;
        cycle();
        idle_inputs();
        checks += 3;
        if (bus.dout !== 32'hB) begin failures++; $display("FAIL mid_ft_dout got=%h exp=b", bus.dout); end
        if (bus.empty !== 1'b0) begin failures++; $display("FAIL mid_ft_empty got=%b exp=0", bus.empty); end
        if (bus.data_count !== 4'd1) begin failures++; $display("FAIL mid_ft_count got=%0d exp=1", bus.data_count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_fall_through();
        do_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_back_to_back();
        test_edge_cases();
        test_random();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
